logic_gate_unit: RTL and testbench

Parametrised, registered successor to the single-bit AND gate. It applies one of eight bitwise logic operations to two WIDTH-bit operands behind a valid/ready handshake. It can also fold a multi-beat burst into a single accumulated result. It sits between an operand producer and a result consumer as a one-stage pipelined logic datapath.

---
 rtl/logic_gate_pkg.sv | 21 ++
 rtl/logic_gate_op.sv | 32 +++
 rtl/logic_gate_unit.sv | 147 ++++++++++++++
 tb/tb_logic_gate_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// rtl/logic_gate_pkg.sv - shared operation codes and FSM state encoding for logic_gate_unit
// Contents:
//   OP_*    : 3-bit operation select codes
//   state_t : burst FSM states (ST_IDLE, ST_ACCUM)
package logic_gate_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_NOR    = 3'd4;
  localparam logic [2:0] OP_XNOR   = 3'd5;
  localparam logic [2:0] OP_ANDNOT = 3'd6;
  localparam logic [2:0] OP_PASS   = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/logic_gate_op.sv
// rtl/logic_gate_op.sv - combinational WIDTH-bit bitwise operation selected by a 3-bit code
// Ports:
//   x, y : operands
//   op   : operation select (OP_* codes)
//   r    : result
module logic_gate_op
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = x & y;
    case (op)
      OP_AND:    r = x & y;
      OP_OR:     r = x | y;
      OP_XOR:    r = x ^ y;
      OP_NAND:   r = ~(x & y);
      OP_NOR:    r = ~(x | y);
      OP_XNOR:   r = ~(x ^ y);
      OP_ANDNOT: r = x & ~y;
      OP_PASS:   r = x;
      default:   r = x & y;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered bitwise logic unit with valid/ready handshake and burst accumulation
// Ports:
//   CLK, RST              : clock, synchronous active-high reset
//   IN_VALID/IN_READY     : operand beat handshake
//   A, B, OP, ACC, LAST   : operands, operation, accumulate-mode request, last-beat marker
//   OUT_VALID/OUT_READY   : result handshake
//   C, Z, BEAT_CNT        : registered result, zero flag, number of beats folded into C
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             ACC,
  input  logic             LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] C,
  output logic             Z,
  output logic [CNT_W-1:0] BEAT_CNT
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;

  logic               out_valid_q;
  logic [WIDTH-1:0]   c_q;
  logic               z_q;
  logic [CNT_W-1:0]   beat_cnt_q;

  logic               accept;
  logic               load_out;
  logic [WIDTH-1:0]   out_data;
  logic [CNT_W-1:0]   out_cnt;
  logic [WIDTH-1:0]   r_ab;
  logic [WIDTH-1:0]   r_acc;

  // Fresh operation on the incoming operands.
  logic_gate_op #(.WIDTH(WIDTH)) u_op_ab (
    .x  (A),
    .y  (B),
    .op (OP),
    .r  (r_ab)
  );

  // Fold of the next beat into the running accumulator with the latched op.
  logic_gate_op #(.WIDTH(WIDTH)) u_op_acc (
    .x  (acc_q),
    .y  (A),
    .op (op_q),
    .r  (r_acc)
  );

  // A pending result that is being taken this cycle frees the output register.
  assign IN_READY = ~out_valid_q | OUT_READY;
  assign accept   = IN_VALID & IN_READY;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
    out_data = r_ab;
    out_cnt  = CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ACC && !LAST) begin
            acc_d   = r_ab;
            op_d    = OP;
            cnt_d   = CNT_W'(1);
            state_d = ST_ACCUM;
          end else begin
            // Single-beat bursts behave exactly like plain beats.
            load_out = 1'b1;
            out_data = r_ab;
            out_cnt  = CNT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = r_acc;
          cnt_d = cnt_inc;
          if (LAST) begin
            load_out = 1'b1;
            out_data = r_acc;
            out_cnt  = cnt_inc;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  // A new result overrides the clear from a completing transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      z_q         <= 1'b1;
      beat_cnt_q  <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      c_q         <= out_data;
      z_q         <= (out_data == '0);
      beat_cnt_q  <= out_cnt;
    end else if (OUT_READY) begin
      out_valid_q <= 1'b0;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign C         = c_q;
  assign Z         = z_q;
  assign BEAT_CNT  = beat_cnt_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb/tb_logic_gate_unit.sv - self-checking bench for logic_gate_unit
module tb_logic_gate_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [2:0] OP = '0;
  logic       ACC = 1'b0;
  logic       LAST = 1'b0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] C;
  logic       Z;
  logic [3:0] BEAT_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the pending result and the open burst.
  bit       init_done = 0;
  bit       m_pend;
  bit [7:0] m_c;
  bit [3:0] m_cnt;
  bit       m_open;
  bit [7:0] m_acc;
  bit [2:0] m_op;
  int       m_beats;

  logic_gate_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .ACC       (ACC),
    .LAST      (LAST),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .C         (C),
    .Z         (Z),
    .BEAT_CNT  (BEAT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [7:0] ref_op(input bit [7:0] a, input bit [7:0] b, input bit [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // One clock: drive inputs, check ready, advance model across the edge, check outputs.
  task automatic cycle(input bit iv, input bit [7:0] a, input bit [7:0] b, input bit [2:0] op,
                       input bit acc, input bit last, input bit ordy, input bit rst);
    bit accept;
    IN_VALID = iv; A = a; B = b; OP = op; ACC = acc; LAST = last; OUT_READY = ordy; RST = rst;
    #1;
    if (init_done) check("in_ready", IN_READY, !m_pend || ordy);
    accept = iv && (!m_pend || ordy);
    @(posedge CLK);
    if (rst) begin
      m_pend = 0; m_c = 0; m_cnt = 0; m_open = 0; m_acc = 0; m_op = 0; m_beats = 0;
      init_done = 1;
    end else begin
      if (m_pend && ordy) m_pend = 0;
      if (accept) begin
        if (!m_open) begin
          if (acc && !last) begin
            m_open = 1; m_acc = ref_op(a, b, op); m_op = op; m_beats = 1;
          end else begin
            m_pend = 1; m_c = ref_op(a, b, op); m_cnt = 1;
          end
        end else begin
          m_acc = ref_op(m_acc, a, m_op);
          m_beats = m_beats + 1;
          if (last) begin
            m_pend = 1; m_c = m_acc; m_cnt = (m_beats > 15) ? 4'd15 : 4'(m_beats);
            m_open = 0;
          end
        end
      end
    end
    #1;
    check("out_valid", OUT_VALID, m_pend);
    check("c", C, m_c);
    check("z", Z, m_c == 0);
    check("beat_cnt", BEAT_CNT, m_cnt);
  endtask

  task automatic idle();
    cycle(0, 8'h00, 8'h00, 3'd0, 0, 0, 1, 0);
  endtask

  initial begin
    bit [7:0] exp_tab [8];
    exp_tab = '{8'h0A, 8'hCF, 8'hC5, 8'hF5, 8'h30, 8'h3A, 8'hC0, 8'hCA};

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cycle($urandom, 8'($urandom), 8'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_c", C, 8'h00);
    check("rst_z", Z, 1);
    check("rst_beat_cnt", BEAT_CNT, 0);
    RST = 0; OUT_READY = 0; IN_VALID = 0;
    #1;
    check("rst_in_ready", IN_READY, 1);

    // All operations, single beats
    for (int op = 0; op < 8; op++) begin
      cycle(1, 8'hCA, 8'h0F, 3'(op), 0, 0, 1, 0);
      check($sformatf("op%0d_c", op), C, exp_tab[op]);
      check($sformatf("op%0d_cnt", op), BEAT_CNT, 1);
      check($sformatf("op%0d_valid", op), OUT_VALID, 1);
    end
    idle();

    // XOR accumulate burst; later beats carry junk B/OP/ACC
    cycle(1, 8'h01, 8'h02, 3'd2, 1, 0, 1, 0);
    check("xor_b1_novalid", OUT_VALID, 0);
    cycle(1, 8'h04, 8'($urandom), 3'($urandom), $urandom, 0, 1, 0);
    check("xor_b2_novalid", OUT_VALID, 0);
    cycle(1, 8'h08, 8'($urandom), 3'($urandom), $urandom, 1, 1, 0);
    check("xor_c", C, 8'h0F);
    check("xor_cnt", BEAT_CNT, 3);
    check("xor_z", Z, 0);
    idle();
    check("xor_single_out", OUT_VALID, 0);

    // AND burst folding to zero
    cycle(1, 8'hF0, 8'hFF, 3'd0, 1, 0, 1, 0);
    cycle(1, 8'h0F, 8'h00, 3'd0, 0, 1, 1, 0);
    check("andz_c", C, 8'h00);
    check("andz_z", Z, 1);
    check("andz_cnt", BEAT_CNT, 2);
    idle();

    // Backpressure
    cycle(1, 8'h12, 8'h34, 3'd1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'($urandom), 8'($urandom), 3'($urandom), 0, 0, 0, 0);
      check("bp_in_ready", IN_READY, 0);
      check("bp_c", C, 8'h36);
      check("bp_cnt", BEAT_CNT, 1);
    end
    cycle(1, 8'h55, 8'h0F, 3'd2, 0, 0, 1, 0);
    check("bp_new_c", C, 8'h5A);
    check("bp_valid_held", OUT_VALID, 1);
    idle();

    // Reset mid-burst
    cycle(1, 8'h11, 8'h22, 3'd1, 1, 0, 1, 0);
    cycle(1, 8'h44, 8'h00, 3'd0, 0, 0, 1, 0);
    cycle(0, 8'h00, 8'h00, 3'd0, 0, 0, 1, 1);
    idle();
    check("rstmid_novalid", OUT_VALID, 0);
    cycle(1, 8'hFF, 8'h3C, 3'd0, 0, 0, 1, 0);
    check("rstmid_c", C, 8'h3C);
    check("rstmid_cnt", BEAT_CNT, 1);
    idle();

    // Long OR burst saturating the beat counter
    cycle(1, 8'h01, 8'h00, 3'd1, 1, 0, 1, 0);
    for (int i = 1; i < 20; i++)
      cycle(1, 8'(1 << (i % 8)), 8'h00, 3'd0, 0, (i == 19), 1, 0);
    check("sat_cnt", BEAT_CNT, 15);
    check("sat_c", C, 8'hFF);
    check("sat_valid", OUT_VALID, 1);
    idle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(3) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
            $urandom_range(1), ($urandom_range(3) == 0), ($urandom_range(3) != 0),
            ($urandom_range(127) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
